// File: rtl/i2c_slave_ram_port.sv
// I2C slave giving a remote master pointer-based read/write access to a 2^RAM_AW x 8 RAM.
// SCL/SDA are oversampled by clk; no clock stretching.
module i2c_slave_ram_port #(
  parameter int SYNC_STAGES = 2,
  parameter int RAM_AW      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_enable,
  input  logic [6:0]        slave_addr,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_w,
  input  logic [7:0]        ram_dout,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WRITE, S_WRITE_ACK, S_READ, S_MACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_c, stop_c;

  // Synchronisers idle high so reset release on a quiet bus creates no edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & sda_d & ~sda_s;
  assign stop_c   = scl_s & ~sda_d & sda_s;

  state_t            st, st_n;
  logic [2:0]        cnt, cnt_n;
  logic              full, full_n;   // 8 bits taken in this byte (MACK: master acked)
  logic [7:0]        shr, shr_n;
  logic [RAM_AW-1:0] ptr, ptr_n;
  logic              sda_oe_n, busy_n, ram_w_n;
  logic [7:0]        ram_din_n;

  assign ram_addr = ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= S_IDLE;
      cnt     <= '0;
      full    <= 1'b0;
      shr     <= '0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      ram_w   <= 1'b0;
      ram_din <= '0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      full    <= full_n;
      shr     <= shr_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      ram_w   <= ram_w_n;
      ram_din <= ram_din_n;
    end
  end

  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    full_n    = full;
    shr_n     = shr;
    ptr_n     = ram_w ? ptr + 1'b1 : ptr;  // post-write increment
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    ram_w_n   = 1'b0;
    ram_din_n = ram_din;
    if (!slave_enable) begin
      st_n     = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_c) begin
      st_n     = S_ADDR;
      cnt_n    = '0;
      full_n   = 1'b0;
      sda_oe_n = 1'b0;
    end else if (stop_c) begin
      st_n     = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      unique case (st)
        S_ADDR, S_PTR, S_WRITE: begin
          if (scl_rise) begin
            shr_n  = {shr[6:0], sda_s};
            cnt_n  = cnt + 3'd1;
            full_n = full | (cnt == 3'd7);
          end
          if (scl_fall && full) begin
            cnt_n  = '0;
            full_n = 1'b0;
            if (st == S_ADDR) begin
              if (shr[7:1] == slave_addr) begin
                st_n     = S_ADDR_ACK;
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
              end else begin
                st_n   = S_IGNORE;
                busy_n = 1'b0;
              end
            end else if (st == S_PTR) begin
              ptr_n    = shr[RAM_AW-1:0];
              st_n     = S_PTR_ACK;
              sda_oe_n = 1'b1;
            end else begin
              ram_w_n   = 1'b1;
              ram_din_n = shr;
              st_n      = S_WRITE_ACK;
              sda_oe_n  = 1'b1;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (shr[0]) begin
            st_n     = S_READ;
            shr_n    = ram_dout;
            sda_oe_n = ~ram_dout[7];
          end else begin
            st_n     = S_PTR;
            sda_oe_n = 1'b0;
          end
        end
        S_PTR_ACK, S_WRITE_ACK: if (scl_fall) begin
          st_n     = S_WRITE;
          sda_oe_n = 1'b0;
        end
        S_READ: begin
          if (scl_rise) begin
            cnt_n  = cnt + 3'd1;
            full_n = full | (cnt == 3'd7);
          end
          if (scl_fall) begin
            if (full) begin
              st_n     = S_MACK;
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              full_n   = 1'b0;
            end else begin
              shr_n    = {shr[6:0], 1'b0};
              sda_oe_n = ~shr[6];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              full_n = 1'b1;
              ptr_n  = ptr + 1'b1;
            end else begin
              st_n   = S_IGNORE;
              busy_n = 1'b0;
            end
          end
          // Pointer moved at the rise; RAM data has settled by the fall.
          if (scl_fall && full) begin
            full_n   = 1'b0;
            shr_n    = ram_dout;
            sda_oe_n = ~ram_dout[7];
            st_n     = S_READ;
          end
        end
        default: sda_oe_n = 1'b0;  // IDLE, IGNORE
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ram_port.sv
// Directed bench for i2c_slave_ram_port: bit-banged I2C master, behavioural RAM, write log.
module tb_i2c_slave_ram_port;
  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n, slave_enable, scl_m, sda_m;
  logic [6:0] slave_addr;
  logic       sda_oe, ram_w, busy, sda_bus;
  logic [4:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0]  mem [32];
  logic [12:0] wq [$];
  logic        mon_en, seen;
  int          n_chk = 0, n_err = 0;

  always #10 clk = ~clk;

  assign sda_bus  = sda_m & ~sda_oe;
  assign ram_dout = mem[ram_addr];

  always @(posedge clk) if (ram_w) begin
    mem[ram_addr] <= ram_din;
    wq.push_back({ram_addr, ram_din});
  end

  always @(posedge clk)
    if (!mon_en) seen <= 1'b0;
    else if (sda_oe || busy || ram_w) seen <= 1'b1;

  i2c_slave_ram_port dut (
    .clk(clk), .reset(rst_n), .slave_enable(slave_enable), .slave_addr(slave_addr),
    .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_w(ram_w), .ram_dout(ram_dout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    ack = sda_bus;
    tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
      b[i] = sda_bus;
      tick(Q); scl_m = 1'b0; tick(Q);
    end
    send_bit(mack);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [12:0] exp);
    chk(tag, (idx < wq.size()) ? {19'd0, wq[idx]} : 32'hdead, {19'd0, exp});
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         base;
    rst_n = 1'b0; slave_enable = 1'b1; slave_addr = 7'h42;
    scl_m = 1'b1; sda_m = 1'b1; mon_en = 1'b0;
    tick(3);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_w", ram_w, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst busy", busy, 0);
    rst_n = 1'b1; tick(4);

    // Write burst
    base = wq.size();
    bus_start;
    send_byte(8'h84, ack); chk("wb ack addr", ack, 0);
    chk("wb busy", busy, 1);
    send_byte(8'h03, ack); chk("wb ack ptr", ack, 0);
    send_byte(8'hA5, ack); chk("wb ack d0", ack, 0);
    send_byte(8'h5A, ack); chk("wb ack d1", ack, 0);
    bus_stop;
    chk("wb busy after P", busy, 0);
    chk("wb nwrites", wq.size() - base, 2);
    chk_wr("wb w0", base, {5'd3, 8'hA5});
    chk_wr("wb w1", base + 1, {5'd4, 8'h5A});
    chk("wb ptr", ram_addr, 5);

    // Wrap write
    base = wq.size();
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h1F, ack);
    send_byte(8'h11, ack); send_byte(8'h22, ack);
    bus_stop;
    chk_wr("wrap w0", base, {5'd31, 8'h11});
    chk_wr("wrap w1", base + 1, {5'd0, 8'h22});
    chk("wrap ptr", ram_addr, 1);

    // Combined read of RAM[7], RAM[8]
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h07, ack);
    send_byte(8'h3C, ack); send_byte(8'hC3, ack);
    bus_stop;
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h07, ack);
    bus_start;
    send_byte(8'h85, ack); chk("rd ack addr", ack, 0);
    chk("rd busy", busy, 1);
    read_byte(1'b0, rd); chk("rd byte0", rd, 8'h3C);
    read_byte(1'b1, rd); chk("rd byte1", rd, 8'hC3);
    chk("rd sda_oe after nack", sda_oe, 0);
    chk("rd busy after nack", busy, 0);
    bus_stop;

    // Address mismatch
    base = wq.size();
    mon_en = 1'b1; tick(2);
    bus_start;
    send_byte(8'h90, ack); chk("mm nack addr", ack, 1);
    send_byte(8'h01, ack); chk("mm nack d0", ack, 1);
    send_byte(8'hFF, ack);
    bus_stop;
    tick(2);
    chk("mm activity", seen, 0);
    chk("mm nwrites", wq.size() - base, 0);
    mon_en = 1'b0;

    // Disable during 4th data bit
    base = wq.size();
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h10, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    slave_enable = 1'b0; tick(1);
    chk("dis sda_oe", sda_oe, 0);
    chk("dis busy", busy, 0);
    tick(Q); scl_m = 1'b0; tick(Q);
    bus_stop;
    slave_enable = 1'b1; tick(2);
    chk("dis ptr kept", ram_addr, 5'h10);
    chk("dis nwrites", wq.size() - base, 0);

    // Reset during 4th data bit
    base = wq.size();
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h11, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    rst_n = 1'b0; #1;
    chk("rstx sda_oe", sda_oe, 0);
    chk("rstx busy", busy, 0);
    chk("rstx ram_addr", ram_addr, 0);
    chk("rstx ram_w", ram_w, 0);
    tick(Q); scl_m = 1'b0; tick(Q);
    bus_stop;
    rst_n = 1'b1; tick(4);
    bus_start;
    send_byte(8'h84, ack); chk("rstx ack addr", ack, 0);
    send_byte(8'h10, ack); send_byte(8'h77, ack);
    bus_stop;
    chk("rstx nwrites", wq.size() - base, 1);
    chk_wr("rstx w0", base, {5'd16, 8'h77});

    // Pointer upper bits ignored; STOP right after pointer ACK, then read
    bus_start;
    send_byte(8'h84, ack); send_byte(8'h02, ack); send_byte(8'h9D, ack);
    bus_stop;
    bus_start;
    send_byte(8'h84, ack); send_byte(8'hE2, ack); chk("gl ack ptr", ack, 0);
    bus_stop;
    chk("gl ptr", ram_addr, 2);
    bus_start;
    send_byte(8'h85, ack);
    read_byte(1'b1, rd); chk("gl read", rd, 8'h9D);
    bus_stop;
    chk("gl busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ram_port.md
Name: i2c_slave_ram_port

Overview:
- I2C slave engine that lets a remote master read and write the board's 32x8 shared RAM.
- Plugs into the slave-mode path of the I2C top level: its RAM outputs feed the remote write/read-address mux into the RAM controller.
- Oversamples SCL/SDA with the system clock and performs pointer-based register access with auto-increment.
- No clock stretching.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (minimum 2).
- RAM_AW, 5, RAM address width; the pointer wraps at 2^RAM_AW-1.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous reset, active-low.
- slave_enable  input  1  1 = respond on the bus; 0 = forced IDLE, SDA released.
- slave_addr  input  7  this device's I2C address; may change only while busy=0.
- scl_in  input  1  bus SCL level.
- sda_in  input  1  bus SDA level.
- sda_oe  output  1  1 = pull SDA low (the top level builds the open-drain pad).
- ram_addr  output  RAM_AW  RAM address, shared by read and write.
- ram_din  output  8  write data to RAM.
- ram_w  output  1  one-clk write strobe.
- ram_dout  input  8  RAM read data; valid ≤2 clk after ram_addr changes.
- busy  output  1  high from an address-matched START until STOP/NACK.

Behaviour:
- Reset (reset=0) values: sda_oe=0, ram_addr=0, ram_din=0, ram_w=0, busy=0, pointer=0, state=IDLE.
- Synchronisation: scl/sda each pass through SYNC_STAGES FFs, then one extra register for edge detection.
  - SCL rise/fall are derived from that edge-detect register.
  - START = synced SDA falls while synced SCL=1; STOP = synced SDA rises while synced SCL=1.
- Precedence:
  - START or STOP in any state overrides everything.
  - START → ADDR (this also covers repeated START).
  - STOP → IDLE; sda_oe drops on the same clk.
- Bit counter: 3 bits. Data is sampled on SCL rise, MSB first. SDA is changed only on the clk after SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th fall:
    - byte[7:1]==slave_addr → ADDR_ACK, busy=1.
    - otherwise → IGNORE (sda_oe=0 until START/STOP).
  - ADDR_ACK: sda_oe=1 for one SCL period (from the 8th fall to the 9th fall). Then:
    - R/W=0 → PTR.
    - R/W=1 → load shift register from ram_dout and enter READ.
  - PTR: shift 8 bits; pointer ← byte[RAM_AW-1:0]; upper bits are ignored. → PTR_ACK (ACK as above) → WRITE.
  - WRITE: shift 8 bits. On the 8th fall: ram_addr=pointer, ram_din=byte, ram_w=1 for exactly 1 clk. Next clk: pointer+1. → WRITE_ACK (ACK) → WRITE.
  - READ:
    - sda_oe=~shift[7], updated after each SCL fall. After the 8th fall, SDA is released → MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): pointer+1 at that rise; on the next fall, load from ram_dout and go to READ.
    - 1 (NACK): → IGNORE, busy=0.
- ram_addr = pointer at all times outside the write strobe; pointer wraps 31→0 in both write and read.
- slave_enable=0 at any time: immediately IDLE, sda_oe=0, busy=0; pointer is kept.
- reset=0 mid-transfer: all outputs go to reset values asynchronously. After release, wait for a fresh START.
- A STOP that arrives after PTR_ACK with no data byte is legal: the pointer is kept for a later read. Reads start from the pointer as it stands.

Test Plan:
- Write burst: slave_addr=0x42; S,0x84,ptr 0x03,data 0xA5,0x5A,P → ACK on all 4 bytes; ram_w pulses at addr 3 din 0xA5 and at addr 4 din 0x5A; pointer=5; busy falls at P.
- Wrap write: ptr 0x1F, data 0x11,0x22 → writes to addr 31 then addr 0.
- Combined read: RAM[7]=0x3C, RAM[8]=0xC3. S,0x84,0x07,Sr,0x85, read 2 bytes with ACK then NACK, P → SDA returns 0x3C then 0xC3. After the NACK, sda_oe=0 and busy=0.
- Address mismatch: S,0x90,0x01,0xFF,P → sda_oe never asserts, no ram_w, busy=0 throughout.
- Disable/reset mid-byte: slave_enable=0 during the 4th data bit → sda_oe=0 within 1 clk, no ram_w. Repeat with reset=0: outputs go to reset values immediately, and the next valid transaction succeeds.
- Glitch/edge: ptr byte 0xE2 → pointer=2 (upper bits ignored). A STOP right after PTR_ACK, followed by a read, returns RAM[2].
